muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Multi-cycle RV32M multiply/divide sequencer beside the single-cycle integer ALU in the execute stage.
- Accepts one operation per start pulse and iterates a shift-add multiply or restoring divide over 32 cycles.
- Holds busy so the pipeline control stalls issue; pulses done with a registered 32-bit result.
- Handles RISC-V divide-by-zero and signed-overflow cases through a one-cycle fast path.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  32  rs1 operand; sampled with start
- b  input  32  rs2 operand; sampled with start
- busy  output  1  high while the operation is in flight (PREP, RUN, FIX)
- done  output  1  single-cycle pulse; result valid in that cycle
- result  output  32  registered result; held until the next accepted start

Behaviour:
- Reset, asserted at any time including mid-operation: state=IDLE, busy=0, done=0, result=0, counter=0. Any in-flight operation is discarded.
- Start acceptance:
  - IDLE with start=1 at edge N latches funct3, a and b.
  - start in any other state is ignored; no queueing.
- Normal path timing:
  - PREP in cycle N+1: computes operand magnitudes and records the result sign from the latched op.
  - RUN for 32 cycles, N+2..N+33.
  - FIX in cycle N+34: conditional two's-complement negate and high/low select.
  - DONE in cycle N+35: done=1, result updated; then IDLE.
  - Fixed latency: done 35 cycles after the start edge.
  - busy=1 in cycles N+1..N+34; busy=0 in DONE.
- Signedness:
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats a as signed and b as unsigned.
  - MULHU/DIVU/REMU treat both operands as unsigned.
- Multiply: 64-bit unsigned product of magnitudes, one bit of b per RUN cycle, LSB first. Negate if signs differ. MUL returns [31:0]; MULH/MULHSU/MULHU return [63:32].
- Divide: restoring divide on magnitudes, one quotient bit per RUN cycle, MSB first. The remainder uses a 33-bit subtract; its sign bit selects restore.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Fast path, decided at the start edge; goes IDLE -> DONE so done=1 in cycle N+1 and busy never asserts:
  - b==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result a.
  - a==0x80000000 with b==0xFFFFFFFF: DIV result 0x80000000; REM result 0. DIVU/REMU do not take this path.
- Boundaries:
  - Counter wraps 31->0 when leaving RUN.
  - start asserted during the DONE cycle is ignored; the earliest accept is the following IDLE cycle.
  - Inputs a, b and funct3 may change freely after the start edge.
- FSM encoding: IDLE=0, PREP=1, RUN=2, FIX=3, DONE=4; 3-bit state register. Unused encodings go to IDLE.

Decomposition:
- Shared package holds:
  - funct3 op constants (MUL..REMU)
  - FSM state encodings
  - DIV_BY_ZERO_Q (0xFFFFFFFF)
  - INT_MIN (0x80000000)
- One natural sub-module: muldiv_step. It is combinational and computes one iteration, either a conditional add-and-shift for multiply or a trial-subtract-and-shift for divide. Inputs: partial accumulator, operand and a mode bit.
- The FSM, counter and sign fix-up stay in muldiv_seq.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done 35 cycles after start, result 0xFFFFFFEB; busy high for exactly 34 cycles.
- MULH a=0x80000000, b=0x80000000 -> result 0x40000000. MULHU with the same operands -> 0x40000000. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-20, b=6 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFE (-2). DIVU a=20, b=6 -> 3. REMU with the same operands -> 2.
- Fast path:
  - DIV a=5, b=0 -> done one cycle after start, result 0xFFFFFFFF, busy stays 0. REMU a=5, b=0 -> 5.
  - DIV a=0x80000000, b=-1 -> 0x80000000. REM with the same operands -> 0.
- Start pulsed during RUN with different operands -> ignored; the original result is returned, and only one done pulse occurs.
- rst asserted in cycle N+10 of a DIV -> busy=0, done=0 and result=0 immediately. A new MUL 6*7 started after release -> 42.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide sequencer: funct3 codes,
// FSM state encodings and the RISC-V special-case result values.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Bit 2 of funct3 separates the divide family from the multiply family.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: shift-add multiply (LSB first) or
// restoring divide (MSB first) on a 64-bit {high, low} accumulator.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    input  logic              is_div_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] trial;

    // Multiply: low half holds the remaining multiplier bits, high half the partial product.
    assign mul_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    assign rem_shift = acc_i[2*XLEN-1:XLEN-1];
    assign trial     = rem_shift - {1'b0, opnd_i};

    always_comb begin
        acc_o = '0;
        if (!is_div_i) begin
            acc_o = {mul_sum, acc_i[XLEN-1:1]};
        end else if (trial[XLEN]) begin
            acc_o = {rem_shift[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end else begin
            acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer: IDLE -> PREP -> RUN x32 -> FIX -> DONE,
// with a direct IDLE -> DONE path for divide-by-zero and signed overflow.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              neg_q, neg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [2*XLEN-1:0] step_acc;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    muldiv_step u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div_op(op_q)),
        .acc_o    (step_acc)
    );

    assign a_signed = is_div_op(op_q) ? !op_q[0] : (op_q != F3_MULHU);
    assign b_signed = is_div_op(op_q) ? !op_q[0] : !op_q[1];
    assign a_neg    = a_signed && a_q[XLEN-1];
    assign b_neg    = b_signed && b_q[XLEN-1];
    assign a_mag    = a_neg ? (~a_q + 1'b1) : a_q;
    assign b_mag    = b_neg ? (~b_q + 1'b1) : b_q;

    assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quot_fix = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    assign rem_fix  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = funct3;
                    a_d  = a;
                    b_d  = b;
                    if (is_div_op(funct3) && b == '0) begin
                        state_d  = ST_DONE;
                        result_d = funct3[1] ? a : DIV_BY_ZERO_Q;
                    end else if (is_div_op(funct3) && !funct3[0] && a == INT_MIN && b == '1) begin
                        state_d  = ST_DONE;
                        result_d = funct3[1] ? '0 : INT_MIN;
                    end else begin
                        state_d = ST_PREP;
                    end
                end
            end
            ST_PREP: begin
                cnt_d   = '0;
                state_d = ST_RUN;
                if (is_div_op(op_q)) begin
                    acc_d  = {{XLEN{1'b0}}, a_mag};
                    opnd_d = b_mag;
                    neg_d  = op_q[1] ? a_neg : (a_neg ^ b_neg);
                end else begin
                    acc_d  = {{XLEN{1'b0}}, b_mag};
                    opnd_d = a_mag;
                    neg_d  = a_neg ^ b_neg;
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                if (is_div_op(op_q)) begin
                    result_d = op_q[1] ? rem_fix : quot_fix;
                end else begin
                    result_d = (op_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_PREP) || (state_d == ST_RUN) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    // NOTE: non-blocking assignments here so every flop samples the pre-edge _d values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
